vx_elastic_pipe: RTL and testbench

VX_ELASTIC_PIPE -- requirements
Module: vx_elastic_pipe

---
 rtl/vx_elastic_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_vx_elastic_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_elastic_pipe.sv
// vx_elastic_pipe
//   Elastic valid/ready pipeline with two flavours:
//     MODE 0 - bubble-collapsing pipe. One entry per stage. A stage accepts
//              when it is empty or when the stage after it accepts, so a
//              bubble lets upstream stages advance while the output stalls.
//              ready_in is combinational from ready_out through full stages.
//     MODE 1 - skid pipe. Each stage has a main and a skid register, and its
//              upstream ready is a flop. There is no combinational path from
//              ready_out to ready_in.
//   STAGES = 0 gives a plain combinational passthrough.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (clears valid state only)
//   flush      synchronous discard of every held entry
//   valid_in   upstream valid         ready_in   upstream ready
//   data_in    upstream payload
//   valid_out  downstream valid       ready_out  downstream ready
//   data_out   downstream payload
//   count      number of entries currently held
module vx_elastic_pipe #(
   parameter  int DATAW  = 32,
   parameter  int STAGES = 2,
   parameter  int MODE   = 0,
   localparam int CAP    = (MODE == 0) ? STAGES : 2 * STAGES,
   localparam int CW     = (CAP == 0) ? 1 : $clog2(CAP + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [DATAW-1:0] data_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [DATAW-1:0] data_out,
   output logic [CW-1:0]    count
);

   if (STAGES == 0) begin : g_pass
      assign ready_in  = ready_out;
      assign valid_out = valid_in;
      assign data_out  = data_in;
      assign count     = {CW{1'b0}};
   end else begin : g_pipe
      logic          accept_s;
      logic          deliver_s;
      logic [CW-1:0] count_r;

      if (MODE == 0) begin : g_bubble
         logic [STAGES-1:0] valid_r;
         logic [STAGES-1:0] stage_ready_s;
         logic [STAGES-1:0] up_valid_s;
         logic [DATAW-1:0]  data_r     [STAGES];
         logic [DATAW-1:0]  up_data_s  [STAGES];

         // Ready chain: a stage is ready if it or any stage below it is empty, or the sink is ready.
         always_comb begin : ready_chain
            logic chain_v;
            chain_v       = ready_out;
            stage_ready_s = {STAGES{1'b0}};
            for (int k = STAGES - 1; k >= 0; k--) begin
               chain_v          = chain_v | ~valid_r[k];
               stage_ready_s[k] = chain_v;
            end
         end

         // Upstream feed of each stage: the input port for stage 0, the previous stage otherwise.
         always_comb begin
            up_valid_s   = {STAGES{1'b0}};
            up_valid_s[0] = valid_in;
            up_data_s[0]  = data_in;
            for (int k = 1; k < STAGES; k++) begin
               up_valid_s[k] = valid_r[k-1];
               up_data_s[k]  = data_r[k-1];
            end
         end

         // Stage valid bits; flush wins over any concurrent load.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               valid_r <= {STAGES{1'b0}};
            end else if (flush) begin
               valid_r <= {STAGES{1'b0}};
            end else begin
               for (int k = 0; k < STAGES; k++) begin
                  if (stage_ready_s[k]) begin
                     valid_r[k] <= up_valid_s[k];
                  end
               end
            end
         end

         // Stage payloads load only with a valid word; never reset.
         always_ff @(posedge clk) begin
            for (int k = 0; k < STAGES; k++) begin
               if (stage_ready_s[k] && up_valid_s[k] && !flush) begin
                  data_r[k] <= up_data_s[k];
               end
            end
         end

         assign ready_in  = stage_ready_s[0] & ~flush;
         assign valid_out = valid_r[STAGES-1];
         assign data_out  = data_r[STAGES-1];
      end else begin : g_skid
         logic [STAGES-1:0] main_v_r;
         logic [STAGES-1:0] skid_v_r;
         logic [STAGES-1:0] rdy_r;
         logic [STAGES-1:0] in_valid_s;
         logic [STAGES-1:0] dn_ready_s;
         logic [STAGES-1:0] acc_s;
         logic [STAGES-1:0] dlv_s;
         logic [STAGES-1:0] main_v_nx_s;
         logic [STAGES-1:0] skid_v_nx_s;
         logic [STAGES-1:0] main_from_skid_s;
         logic [STAGES-1:0] load_main_s;
         logic [STAGES-1:0] load_skid_s;
         logic [DATAW-1:0]  main_d_r  [STAGES];
         logic [DATAW-1:0]  skid_d_r  [STAGES];
         logic [DATAW-1:0]  in_data_s [STAGES];

         // Stage links: feed from the previous main register, ready from the next stage's flop.
         always_comb begin
            in_valid_s    = {STAGES{1'b0}};
            dn_ready_s    = {STAGES{1'b0}};
            in_valid_s[0] = valid_in;
            in_data_s[0]  = data_in;
            for (int k = 1; k < STAGES; k++) begin
               in_valid_s[k] = main_v_r[k-1];
               in_data_s[k]  = main_d_r[k-1];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
               dn_ready_s[k] = rdy_r[k+1];
            end
            dn_ready_s[STAGES-1] = ready_out;
         end

         // Per-stage next state. A held skid word always refills main before new input;
         // rdy_r is low whenever the skid is full, so accept and skid-valid never coincide.
         always_comb begin
            acc_s            = {STAGES{1'b0}};
            dlv_s            = {STAGES{1'b0}};
            main_v_nx_s      = {STAGES{1'b0}};
            skid_v_nx_s      = {STAGES{1'b0}};
            main_from_skid_s = {STAGES{1'b0}};
            load_main_s      = {STAGES{1'b0}};
            load_skid_s      = {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
               acc_s[k] = in_valid_s[k] & rdy_r[k];
               dlv_s[k] = main_v_r[k] & dn_ready_s[k];
               if (!main_v_r[k] || dlv_s[k]) begin
                  if (skid_v_r[k]) begin
                     main_v_nx_s[k]      = 1'b1;
                     skid_v_nx_s[k]      = 1'b0;
                     main_from_skid_s[k] = 1'b1;
                  end else begin
                     main_v_nx_s[k] = acc_s[k];
                     skid_v_nx_s[k] = 1'b0;
                     load_main_s[k] = acc_s[k];
                  end
               end else begin
                  main_v_nx_s[k] = 1'b1;
                  skid_v_nx_s[k] = skid_v_r[k] | acc_s[k];
                  load_skid_s[k] = acc_s[k];
               end
            end
         end

         // Valid, skid-valid and registered ready; ready stays low while reset is held.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               main_v_r <= {STAGES{1'b0}};
               skid_v_r <= {STAGES{1'b0}};
               rdy_r    <= {STAGES{1'b0}};
            end else if (flush) begin
               main_v_r <= {STAGES{1'b0}};
               skid_v_r <= {STAGES{1'b0}};
               rdy_r    <= {STAGES{1'b1}};
            end else begin
               main_v_r <= main_v_nx_s;
               skid_v_r <= skid_v_nx_s;
               rdy_r    <= ~skid_v_nx_s;
            end
         end

         // Main and skid payloads; never reset.
         always_ff @(posedge clk) begin
            for (int k = 0; k < STAGES; k++) begin
               if (!flush) begin
                  if (main_from_skid_s[k]) begin
                     main_d_r[k] <= skid_d_r[k];
                  end else if (load_main_s[k]) begin
                     main_d_r[k] <= in_data_s[k];
                  end
                  if (load_skid_s[k]) begin
                     skid_d_r[k] <= in_data_s[k];
                  end
               end
            end
         end

         assign ready_in  = rdy_r[0] & ~flush;
         assign valid_out = main_v_r[STAGES-1];
         assign data_out  = main_d_r[STAGES-1];
      end

      assign accept_s  = valid_in & ready_in;
      assign deliver_s = valid_out & ready_out;

      // Occupancy counter: +1 on accept, -1 on deliver, cleared by flush.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            count_r <= {CW{1'b0}};
         end else if (flush) begin
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + CW'(accept_s) - CW'(deliver_s);
         end
      end

      assign count = count_r;
   end

endmodule

// File: tb/tb_vx_elastic_pipe.sv
// tb_vx_elastic_pipe
//   Directed bench for vx_elastic_pipe with DATAW=8, STAGES=3.
//   Instance a: MODE 0 (bubble-collapsing), instance b: MODE 1 (skid).
//   Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
module tb_vx_elastic_pipe;
   logic       clk;
   logic       reset_n;

   logic       a_flush, a_valid_in, a_ready_in, a_valid_out, a_ready_out;
   logic [7:0] a_data_in, a_data_out;
   logic [1:0] a_count;

   logic       b_flush, b_valid_in, b_ready_in, b_valid_out, b_ready_out;
   logic [7:0] b_data_in, b_data_out;
   logic [2:0] b_count;

   int checks = 0;
   int errors = 0;

   vx_elastic_pipe #(.DATAW(8), .STAGES(3), .MODE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .flush(a_flush),
      .valid_in(a_valid_in), .ready_in(a_ready_in), .data_in(a_data_in),
      .valid_out(a_valid_out), .ready_out(a_ready_out), .data_out(a_data_out),
      .count(a_count)
   );

   vx_elastic_pipe #(.DATAW(8), .STAGES(3), .MODE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .flush(b_flush),
      .valid_in(b_valid_in), .ready_in(b_ready_in), .data_in(b_data_in),
      .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out),
      .count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      a_flush = 1'b0; a_valid_in = 1'b0; a_ready_out = 1'b0; a_data_in = 8'h00;
      b_flush = 1'b0; b_valid_in = 1'b0; b_ready_out = 1'b0; b_data_in = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst_a_valid_out", a_valid_out, 32'd0);
      check("rst_a_count",     a_count,     32'd0);
      check("rst_a_ready_in",  a_ready_in,  32'd1);
      check("rst_b_valid_out", b_valid_out, 32'd0);
      check("rst_b_count",     b_count,     32'd0);
      check("rst_b_ready_in",  b_ready_in,  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rel_b_ready_in_pre", b_ready_in, 32'd0);
      cyc();
      #1;
      check("rel_b_ready_in_post", b_ready_in, 32'd1);

      // MODE 0 streaming: 0x01..0x0A back-to-back with the sink always ready
      for (int c = 0; c < 14; c++) begin
         int acc_n;
         int dlv_n;
         cyc();
         a_ready_out = 1'b1;
         a_valid_in  = (c < 10);
         a_data_in   = 8'(c + 1);
         #1;
         acc_n = (c < 10) ? c : 10;
         dlv_n = (c < 3) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
         check("s34_ready_in",  a_ready_in,  32'd1);
         check("s34_valid_out", a_valid_out, 32'((c >= 3) && (c <= 12)));
         if ((c >= 3) && (c <= 12)) check("s34_data_out", a_data_out, 32'(c - 2));
         check("s34_count", a_count, 32'(acc_n - dlv_n));
      end

      // MODE 0 full: accept and deliver in the same cycle
      cyc(); a_ready_out = 1'b0; a_valid_in = 1'b1; a_data_in = 8'h11; #1;
      check("s35_ready_empty", a_ready_in, 32'd1);
      cyc(); a_data_in = 8'h22; #1;
      cyc(); a_data_in = 8'h33; #1;
      cyc(); a_data_in = 8'h44; #1;
      check("s35_ready_full", a_ready_in,  32'd0);
      check("s35_count_full", a_count,     32'd3);
      check("s35_head_valid", a_valid_out, 32'd1);
      check("s35_head_data",  a_data_out,  32'h11);
      a_ready_out = 1'b1; #1;
      check("s35_ready_pass", a_ready_in, 32'd1);
      cyc(); a_valid_in = 1'b0; #1;
      check("s35_count_same", a_count,    32'd3);
      check("s35_data_22",    a_data_out, 32'h22);
      cyc(); #1;
      check("s35_data_33", a_data_out, 32'h33);
      check("s35_count_2", a_count,    32'd2);
      cyc(); #1;
      check("s35_data_44", a_data_out, 32'h44);
      cyc(); #1;
      check("s35_drained_valid", a_valid_out, 32'd0);
      check("s35_drained_count", a_count,     32'd0);

      // MODE 0 bubble collapse with the sink stalled
      cyc(); a_ready_out = 1'b0; a_valid_in = 1'b1; a_data_in = 8'hAA; #1;
      cyc(); a_valid_in = 1'b0; #1;
      cyc(); #1;
      cyc(); a_valid_in = 1'b1; a_data_in = 8'hBB; #1;
      check("s36_aa_head",  a_data_out, 32'hAA);
      check("s36_count_1",  a_count,    32'd1);
      cyc(); a_valid_in = 1'b0; #1;
      check("s36_count_2",  a_count,    32'd2);
      check("s36_ready_in", a_ready_in, 32'd1);
      cyc(); a_valid_in = 1'b1; a_data_in = 8'hCC; #1;
      check("s36_ready_s0_free", a_ready_in, 32'd1);
      cyc(); a_valid_in = 1'b0; #1;
      check("s36_count_3", a_count,    32'd3);
      check("s36_ready_0", a_ready_in, 32'd0);
      a_ready_out = 1'b1; #1;
      check("s36_out_aa", a_data_out, 32'hAA);
      cyc(); #1;
      check("s36_out_bb", a_data_out, 32'hBB);
      cyc(); #1;
      check("s36_out_cc", a_data_out, 32'hCC);
      cyc(); #1;
      check("s36_empty", a_valid_out, 32'd0);

      // MODE 0 flush with two held words and a concurrent push
      cyc(); a_ready_out = 1'b0; a_valid_in = 1'b1; a_data_in = 8'h51; #1;
      cyc(); a_data_in = 8'h52; #1;
      cyc(); a_data_in = 8'h53; a_flush = 1'b1; #1;
      check("s38a_count_2",  a_count,    32'd2);
      check("s38a_ready_in", a_ready_in, 32'd0);
      cyc(); a_flush = 1'b0; a_valid_in = 1'b0; a_ready_out = 1'b1; #1;
      check("s38a_count_0", a_count,     32'd0);
      check("s38a_valid_0", a_valid_out, 32'd0);
      for (int c = 0; c < 4; c++) begin
         cyc(); #1;
         check("s38a_no_ghost", a_valid_out, 32'd0);
      end
      a_ready_out = 1'b0;

      // MODE 1 skid fill with the sink stalled, then release
      for (int c = 0; c < 10; c++) begin
         cyc();
         b_ready_out = 1'b0;
         b_valid_in  = 1'b1;
         b_data_in   = 8'(8'h61 + ((c < 6) ? c : 6));
         #1;
         check("s37_ready_in", b_ready_in, 32'(c < 6));
      end
      check("s37_count_6",    b_count,     32'd6);
      check("s37_head_valid", b_valid_out, 32'd1);
      check("s37_head_data",  b_data_out,  32'h61);
      b_valid_in = 1'b0; b_ready_out = 1'b1; #1;
      check("s37_out_valid", b_valid_out, 32'd1);
      check("s37_out_data",  b_data_out,  32'h61);
      for (int k = 1; k < 6; k++) begin
         cyc(); #1;
         check("s37_out_valid", b_valid_out, 32'd1);
         check("s37_out_data",  b_data_out,  32'(8'h61 + k));
      end
      cyc(); #1;
      check("s37_empty_valid", b_valid_out, 32'd0);
      check("s37_empty_count", b_count,     32'd0);

      // MODE 1 flush with two held words and a concurrent push
      cyc(); b_ready_out = 1'b0; b_valid_in = 1'b1; b_data_in = 8'h91; #1;
      cyc(); b_data_in = 8'h92; #1;
      cyc(); b_data_in = 8'h93; b_flush = 1'b1; #1;
      check("s38b_count_2",  b_count,    32'd2);
      check("s38b_ready_in", b_ready_in, 32'd0);
      cyc(); b_flush = 1'b0; b_valid_in = 1'b0; b_ready_out = 1'b1; #1;
      check("s38b_count_0",  b_count,     32'd0);
      check("s38b_valid_0",  b_valid_out, 32'd0);
      check("s38b_ready_in", b_ready_in,  32'd1);
      for (int c = 0; c < 4; c++) begin
         cyc(); #1;
         check("s38b_no_ghost", b_valid_out, 32'd0);
      end

      // Mid-traffic reset pulse with three held words in each instance
      cyc();
      a_ready_out = 1'b0; a_valid_in = 1'b1; a_data_in = 8'h71;
      b_ready_out = 1'b0; b_valid_in = 1'b1; b_data_in = 8'h71;
      #1;
      cyc(); a_data_in = 8'h72; b_data_in = 8'h72; #1;
      cyc(); a_data_in = 8'h73; b_data_in = 8'h73; #1;
      cyc(); a_valid_in = 1'b0; b_valid_in = 1'b0; #1;
      check("s39_a_count_3", a_count, 32'd3);
      check("s39_b_count_3", b_count, 32'd3);
      #1;
      reset_n = 1'b0;
      #1;
      check("s39_a_valid_0", a_valid_out, 32'd0);
      check("s39_a_count_0", a_count,     32'd0);
      check("s39_a_ready_1", a_ready_in,  32'd1);
      check("s39_b_valid_0", b_valid_out, 32'd0);
      check("s39_b_count_0", b_count,     32'd0);
      check("s39_b_ready_0", b_ready_in,  32'd0);
      #3;
      reset_n = 1'b1;
      a_ready_out = 1'b1;
      b_ready_out = 1'b1;
      for (int c = 0; c < 7; c++) begin
         cyc();
         a_valid_in = (c == 0); a_data_in = 8'h81;
         b_valid_in = (c == 0); b_data_in = 8'h82;
         #1;
         if (c == 0) check("s39_b_ready_back", b_ready_in, 32'd1);
         check("s39_a_valid", a_valid_out, 32'(c == 3));
         check("s39_b_valid", b_valid_out, 32'(c == 3));
         if (c == 3) begin
            check("s39_a_data", a_data_out, 32'h81);
            check("s39_b_data", b_data_out, 32'h82);
         end
      end
      check("s39_a_count_end", a_count, 32'd0);
      check("s39_b_count_end", b_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
